// File: rtl/sum_accumulator_pkg.sv
// Shared types and widths for the sum_accumulator block.
// Sample width matches the 4-bit ripple adder result {C4, S[3:0]}.
package sum_accumulator_pkg;

  localparam int SAMPLE_W = 5;
  localparam int CNT_W    = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/sum_accumulator_add.sv
// Combinational accumulate step: acc + sample with sticky overflow.
// Build option: SUM_ACCUMULATOR_SAT_EN selects saturating (defined) or wrapping (undefined) sums.
module sum_accumulator_add
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0]    acc_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                ovf_i,
  output logic [ACC_W-1:0]    sum_o,
  output logic                ovf_o
);

  logic [ACC_W:0] sum_full;
  logic           carry;

  // One extra bit is enough: a sample never exceeds 2^ACC_W-1 on its own.
  assign sum_full = {1'b0, acc_i} + {{(ACC_W + 1 - SAMPLE_W){1'b0}}, sample_i};
  assign carry    = sum_full[ACC_W];
  assign ovf_o    = ovf_i | carry;

`ifdef SUM_ACCUMULATOR_SAT_EN
  // Once clamped, any further nonzero add carries out again, so acc stays at max.
  assign sum_o = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
  assign sum_o = sum_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Block accumulator for adder results: sums fixed-length (or flushed) blocks and
// presents total/count/overflow on a held valid/ready output. Build option: SUM_ACCUMULATOR_SAT_EN.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W     = 8,
  parameter int BLOCK_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_s,
  input  logic             in_c4,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_LEN);

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_W-1:0]     out_sum_q, out_sum_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;

  logic [SAMPLE_W-1:0]  sample;
  logic [ACC_W-1:0]     add_sum;
  logic                 add_ovf;

  assign sample = {in_c4, in_s};

  sum_accumulator_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i    (acc_q),
    .sample_i (sample),
    .ovf_i    (ovf_q),
    .sum_o    (add_sum),
    .ovf_o    (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = add_ovf;
        end
        // Close on the filling sample, or on flush once the block holds anything.
        if ((in_valid && (cnt_d == BLOCK_CNT)) || (flush && (cnt_d != '0))) begin
          state_d     = HOLD;
          out_sum_d   = acc_d;
          out_count_d = cnt_d;
          out_ovf_d   = ovf_d;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
